hatch_seq: RTL and testbench
============================

HATCH_SEQ -- requirements
Module: hatch_seq

Interface
REQ-001 Parameter FRAME_TICKS, default 500, sets the clk cycles per animation frame (500 = 0.5 s at 1 kHz); legal range 2..1023.
REQ-002 Parameter LAST_FRAME, default 11, sets the final frame index (the hatched chick); legal range 1..15.
REQ-003 clk  input  1  1 kHz system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  asynchronous start/restart button, level.
REQ-006 pause  input  1  asynchronous pause/resume toggle button, level.
REQ-007 num  output  4  current frame index; drives the dot-matrix display driver frame input.
REQ-008 frame_stb  output  1  one-cycle pulse, high in the same cycle that num takes a new value.
REQ-009 busy  output  1  high in RUN or PAUSE.
REQ-010 done  output  1  high in DONE.

Function
REQ-011 Each of start and pause SHALL pass through a 2-flop synchronizer followed by a rising-edge detector (sync2 & ~sync2_d).
REQ-012 An input first sampled high at clk edge k SHALL take effect at edge k+2; a level held high SHALL produce exactly one event.
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE and DONE, encoded in 2 bits.
REQ-014 IDLE: num=0, tick counter=0; a start event SHALL go to RUN, clear the tick counter and pulse frame_stb; pause events SHALL be ignored.
REQ-015 RUN: a 10-bit tick counter SHALL count 0..FRAME_TICKS-1; at terminal count it SHALL wrap to 0, num SHALL increment by 1, and frame_stb SHALL pulse.
REQ-016 RUN: when the increment makes num equal LAST_FRAME, the FSM SHALL enter DONE on the same edge.
REQ-017 RUN: a pause event SHALL go to PAUSE and freeze both the tick counter and num; start events SHALL be ignored.
REQ-018 RUN: if a pause event coincides with terminal count, the pause SHALL win; num is not incremented and the counter holds at FRAME_TICKS-1.
REQ-019 PAUSE: a pause event SHALL return to RUN and resume from the frozen counter value.
REQ-020 PAUSE: a start event SHALL restart (num=0, counter=0, state RUN, frame_stb pulse); start SHALL take priority over a simultaneous pause.
REQ-021 DONE: num SHALL hold LAST_FRAME and done SHALL be 1; a start event SHALL restart exactly as in REQ-020; pause events SHALL be ignored.
REQ-022 num, frame_stb, busy and done SHALL all be registered; no combinational path from inputs to outputs.
REQ-023 num SHALL never exceed LAST_FRAME, and the tick counter SHALL never exceed FRAME_TICKS-1.

Reset
REQ-024 While rst is high: state IDLE, num=0, frame_stb=0, busy=0, done=0, tick counter=0, all synchronizer and edge-detector flops=0.
REQ-025 Reset asserted mid-RUN or mid-PAUSE SHALL abort immediately, with no further frame_stb pulse.
REQ-026 After rst is released, a start level still held high SHALL produce one start event, since the edge detector's previous-value flop is 0.

Configuration
REQ-027 Macro HATCH_LOOP_EN SHALL control auto-looping.
REQ-028 With HATCH_LOOP_EN defined, DONE SHALL reuse the tick counter; after FRAME_TICKS cycles in DONE it SHALL return to RUN with num=0, counter=0 and a frame_stb pulse.
REQ-029 Without HATCH_LOOP_EN, DONE SHALL persist until a start event or rst.

Verification (FRAME_TICKS=4, LAST_FRAME=11)
REQ-030 Reset, then start held high for 10 cycles: exactly one RUN entry, busy=1 at edge k+2, num=0, one frame_stb pulse.
REQ-031 Free run: num steps 0->1->...->11 every 4 cycles, 12 frame_stb pulses total; done=1 and busy=0 on the edge num=11.
REQ-032 Pause at num=5 with counter=2, hold 20 cycles: num stays 5; second pause event resumes and num=6 arrives after 2 more cycles (counter 2->3->wrap).
REQ-033 Start and pause events in the same cycle during PAUSE at num=7: restart to num=0 in RUN with a frame_stb pulse.
REQ-034 rst pulsed mid-run at num=9: all outputs 0 asynchronously; no frame_stb pulse after release without a new start.
REQ-035 DONE with HATCH_LOOP_EN: num=0 and a frame_stb pulse exactly 4 cycles after entering DONE; without the macro, DONE holds for 100 cycles.

Source files
------------

// File: rtl/hatch_seq.sv
// Egg-hatching animation sequencer: steps a frame index every FRAME_TICKS clocks.
// Define HATCH_LOOP_EN to make DONE restart the animation automatically after one frame time.
`timescale 1ns/1ps

// Two-flop synchronizer plus rising-edge detector for an asynchronous button level.
module hatch_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse_c
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign pulse_c = sync2 & ~sync2_d;

endmodule

module hatch_seq #(
  parameter int unsigned FRAME_TICKS = 500,
  parameter int unsigned LAST_FRAME  = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] num,
  output logic       frame_stb,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TICK_W = 10;
  localparam int unsigned NUM_W  = 4;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);
  localparam logic [NUM_W-1:0]  NUM_LAST  = NUM_W'(LAST_FRAME);
  localparam logic [NUM_W-1:0]  NUM_ONE   = NUM_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic              start_ev_c;
  logic              pause_ev_c;

  hatch_edge_sync u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .din     (start),
    .pulse_c (start_ev_c)
  );

  hatch_edge_sync u_pause_sync (
    .clk     (clk),
    .rst     (rst),
    .din     (pause),
    .pulse_c (pause_ev_c)
  );

  // Sequencer: busy/done are set alongside every state change so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      num       <= '0;
      frame_stb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev_c) begin
            state     <= RUN;
            tick      <= '0;
            num       <= '0;
            frame_stb <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        RUN: begin
          // Pause beats a coinciding terminal count: counter stays at TICK_LAST.
          if (pause_ev_c) begin
            state <= PAUSE;
          end else if (tick == TICK_LAST) begin
            tick      <= '0;
            num       <= num + NUM_ONE;
            frame_stb <= 1'b1;
            if ((num + NUM_ONE) == NUM_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end

        PAUSE: begin
          if (start_ev_c) begin
            state     <= RUN;
            tick      <= '0;
            num       <= '0;
            frame_stb <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else if (pause_ev_c) begin
            state <= RUN;
          end
        end

        DONE: begin
          if (start_ev_c) begin
            state     <= RUN;
            tick      <= '0;
            num       <= '0;
            frame_stb <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
`ifdef HATCH_LOOP_EN
          else if (tick == TICK_LAST) begin
            state     <= RUN;
            tick      <= '0;
            num       <= '0;
            frame_stb <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else begin
            tick <= tick + TICK_ONE;
          end
`else
          else begin
            tick <= '0;
          end
`endif
        end

        default: begin
          state <= IDLE;
          tick  <= '0;
          num   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hatch_seq.sv
// Self-checking bench for hatch_seq: frame-level reference model plus directed and random stimulus.
`timescale 1ns/1ps

module tb_hatch_seq;

  localparam int unsigned FT = 4;
  localparam int unsigned LF = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] num;
  logic       frame_stb;
  logic       busy;
  logic       done;

  hatch_seq #(.FRAME_TICKS(FT), .LAST_FRAME(LF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .num       (num),
    .frame_stb (frame_stb),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int stb_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: animation phase, frame number and cycles spent in the current frame.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t    m_mode    = M_IDLE;
  int       m_frame   = 0;
  int       m_elapsed = 0;
  bit       m_stb     = 1'b0;
  bit [3:0] s_hist    = '0;
  bit [3:0] p_hist    = '0;
  bit       sev;
  bit       pev;

  task automatic m_restart();
    m_mode    = M_RUN;
    m_frame   = 0;
    m_elapsed = 0;
    m_stb     = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = M_IDLE; m_frame = 0; m_elapsed = 0; m_stb = 1'b0;
        s_hist = '0; p_hist = '0;
      end else begin
        // A button level sampled two edges ago that was low three edges ago is an event now.
        s_hist = {s_hist[2:0], start};
        p_hist = {p_hist[2:0], pause};
        sev = s_hist[2] && !s_hist[3];
        pev = p_hist[2] && !p_hist[3];
        m_stb = 1'b0;
        case (m_mode)
          M_IDLE:  if (sev) m_restart();
          M_RUN: begin
            if (pev) m_mode = M_PAUSE;
            else begin
              m_elapsed++;
              if (m_elapsed == FT) begin
                m_elapsed = 0;
                m_frame++;
                m_stb = 1'b1;
                if (m_frame == LF) m_mode = M_DONE;
              end
            end
          end
          M_PAUSE: begin
            if (sev) m_restart();
            else if (pev) m_mode = M_RUN;
          end
          M_DONE: begin
            if (sev) m_restart();
`ifdef HATCH_LOOP_EN
            else begin
              m_elapsed++;
              if (m_elapsed == FT) m_restart();
            end
`endif
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("num", int'(num), m_frame);
      check("frame_stb", int'(frame_stb), int'(m_stb));
      check("busy", int'(busy), int'(m_mode == M_RUN || m_mode == M_PAUSE));
      check("done", int'(done), int'(m_mode == M_DONE));
      if (frame_stb) stb_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frame(input int nv, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (frame_stb && int'(num) == nv) hit = 1'b1;
    end
    check(name, int'(hit), 1);
  endtask

  initial begin
    int s0;
    // Reset state
    repeat (3) step();
    check("rst_num", int'(num), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_stb", int'(frame_stb), 0);
    rst = 1'b0;
    step();

    // Held start: one event, effective two edges after first sample
    stb_cnt = 0;
    start = 1'b1;
    step();
    check("start_lat_k", int'(busy), 0);
    step();
    check("start_lat_k1", int'(busy), 0);
    step();
    check("start_busy_k2", int'(busy), 1);
    check("start_num_k2", int'(num), 0);
    check("start_stb_k2", int'(frame_stb), 1);
    repeat (7) step();
    start = 1'b0;

    // Free run to the hatched chick
    wait_frame(LF, 200, "reach_last");
    check("last_done", int'(done), 1);
    check("last_busy", int'(busy), 0);
    check("last_stb_total", stb_cnt, 12);
`ifdef HATCH_LOOP_EN
    repeat (3) step();
    check("loop_hold_num", int'(num), 11);
    check("loop_hold_done", int'(done), 1);
    step();
    check("loop_num", int'(num), 0);
    check("loop_stb", int'(frame_stb), 1);
    check("loop_busy", int'(busy), 1);
`else
    repeat (100) step();
    check("hold_done", int'(done), 1);
    check("hold_num", int'(num), 11);
    check("hold_stb_total", stb_cnt, 12);
`endif

    // Pause at frame 5 with counter at 2, then resume
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame(5, 200, "reach_5");
    pause = 1'b1;
    repeat (20) step();
    pause = 1'b0;
    check("pause_num", int'(num), 5);
    check("pause_busy", int'(busy), 1);
    repeat (3) step();
    pause = 1'b1;
    repeat (4) step();
    check("resume_num_pre", int'(num), 5);
    step();
    check("resume_num", int'(num), 6);
    check("resume_stb", int'(frame_stb), 1);
    pause = 1'b0;

    // Start and pause together while paused at frame 7
    wait_frame(7, 200, "reach_7");
    pause = 1'b1;
    step();
    pause = 1'b0;
    repeat (5) step();
    check("paused7_num", int'(num), 7);
    start = 1'b1;
    pause = 1'b1;
    repeat (3) step();
    check("both_num", int'(num), 0);
    check("both_stb", int'(frame_stb), 1);
    check("both_busy", int'(busy), 1);
    start = 1'b0;
    pause = 1'b0;

    // Asynchronous reset mid-run at frame 9
    wait_frame(9, 200, "reach_9");
    #3;
    rst = 1'b1;
    #1;
    check("arst_num", int'(num), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_stb", int'(frame_stb), 0);
    step();
    rst = 1'b0;
    s0 = stb_cnt;
    repeat (20) step();
    check("post_rst_stb", stb_cnt - s0, 0);
    check("post_rst_busy", int'(busy), 0);

    // Randomized buttons and occasional resets, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) start = ~start;
      if ($urandom_range(0, 11) == 0) pause = ~pause;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      step();
    end
    start = 1'b0;
    pause = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
